// File: rtl/clk_div_edge_gen_if.sv
// Control/status bundle for clk_div_edge_gen: run/load/divider/phase inputs and
// the generated clock, strobes, edge count and busy flag.
`timescale 1ns/1ps
interface clk_div_edge_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic             load;
  logic [DIV_W-1:0] div_half;
  logic [1:0]       phase_sel;
  logic             clk_out;
  logic             clk_out_dly;
  logic             rise_stb;
  logic             fall_stb;
  logic [CNT_W-1:0] edge_cnt;
  logic             busy;

  modport master (
    output en, load, div_half, phase_sel,
    input  clk_out, clk_out_dly, rise_stb, fall_stb, edge_cnt, busy
  );

  modport slave (
    input  en, load, div_half, phase_sel,
    output clk_out, clk_out_dly, rise_stb, fall_stb, edge_cnt, busy
  );
endinterface

// File: rtl/clk_div_edge_gen.sv
// Glitch-free divided clock with rise/fall strobes and a wrapping rising-edge count.
// Optional phase-delayed copy of the clock when PHASE_DLY_EN is defined.
`timescale 1ns/1ps
module clk_div_edge_gen #(
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 1,
  parameter int CNT_W     = 4,
  parameter int DLY_DEPTH = 3
) (
  input  logic               clk_100M,
  input  logic               rst,
  clk_div_edge_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO} state_t;

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] hc_q, hc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_half;
  logic             apply;

  // A half-period of zero would never terminate; treat it as one cycle.
  function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    clk_out_d = clk_out_q;
    apply     = 1'b0;
    last_half = (hc_q == div_q - ONE);
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = RUN_HI;
          hc_d      = '0;
          clk_out_d = 1'b1;
          apply     = 1'b1;
        end
      end
      RUN_HI: begin
        // A stop request only takes effect once the high phase is complete.
        if (last_half) begin
          state_d   = bus.en ? RUN_LO : IDLE;
          hc_d      = '0;
          clk_out_d = 1'b0;
        end else begin
          hc_d = hc_q + ONE;
        end
      end
      RUN_LO: begin
        if (!bus.en) begin
          state_d = IDLE;
          hc_d    = '0;
        end else if (last_half) begin
          state_d   = RUN_HI;
          hc_d      = '0;
          clk_out_d = 1'b1;
          apply     = 1'b1;
        end else begin
          hc_d = hc_q + ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        hc_d      = '0;
        clk_out_d = 1'b0;
      end
    endcase

    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply && pend_vld_q) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    // A load coinciding with an apply stays pending for the next high phase.
    if (bus.load) begin
      pend_d     = sanitize_div(bus.div_half);
      pend_vld_d = 1'b1;
    end

    rise_d = clk_out_d & ~clk_out_q;
    fall_d = ~clk_out_d & clk_out_q;
    cnt_d  = cnt_q + CNT_W'(rise_d);
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hc_q       <= '0;
      div_q      <= DEF_VAL;
      pend_q     <= DEF_VAL;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      busy_q     <= (state_d != IDLE);
      cnt_q      <= cnt_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.rise_stb = rise_q;
  assign bus.fall_stb = fall_q;
  assign bus.edge_cnt = cnt_q;
  assign bus.busy     = busy_q;

`ifdef PHASE_DLY_EN
  localparam int SEL_W = $clog2(DLY_DEPTH + 1);

  logic [DLY_DEPTH:1] dly_q;
  logic [DLY_DEPTH:0] taps;
  logic [SEL_W-1:0]   sel;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
    end else begin
      dly_q[1] <= clk_out_q;
      for (int k = 2; k <= DLY_DEPTH; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  // Tap 0 is the undelayed clock; out-of-range selects clamp to the deepest tap.
  always_comb begin
    if (32'(bus.phase_sel) > DLY_DEPTH) begin
      sel = SEL_W'(DLY_DEPTH);
    end else begin
      sel = SEL_W'(bus.phase_sel);
    end
  end

  assign taps            = {dly_q, clk_out_q};
  assign bus.clk_out_dly = taps[sel];
`else
  logic unused_phase_sel;
  assign unused_phase_sel = ^bus.phase_sel;
  assign bus.clk_out_dly  = clk_out_q;
`endif

endmodule

// File: tb/tb_clk_div_edge_gen.sv
// Self-checking bench for clk_div_edge_gen against a phase-countdown reference model.
`timescale 1ns/1ps
module tb_clk_div_edge_gen;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  clk_div_edge_gen_if #(.DIV_W(8), .CNT_W(4)) bus ();

  clk_div_edge_gen #(.DIV_W(8), .DEF_DIV(1), .CNT_W(4), .DLY_DEPTH(3)) dut (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "running", current level, cycles left in this phase.
  bit         m_run, m_lvl, m_pvld, m_rise, m_fall;
  int         m_rem, m_div, m_pend, m_cnt;
  logic [3:1] m_hist;

  task automatic model_reset();
    m_run = 0; m_lvl = 0; m_pvld = 0; m_rise = 0; m_fall = 0;
    m_rem = 0; m_div = 1; m_pend = 1; m_cnt = 0; m_hist = '0;
  endtask

  task automatic model_step();
    bit prev;
    bit start_hi;
    if (rst) begin
      model_reset();
      return;
    end
    prev     = m_lvl;
    start_hi = 0;
    m_hist   = {m_hist[2:1], prev};
    if (!m_run) begin
      start_hi = bus.en;
    end else if (m_lvl) begin
      m_rem--;
      if (m_rem == 0) begin
        m_lvl = 0;
        m_run = bus.en;
        m_rem = m_div;
      end
    end else if (!bus.en) begin
      m_run = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) start_hi = 1;
    end
    if (start_hi) begin
      if (m_pvld) begin
        m_div  = m_pend;
        m_pvld = 0;
      end
      m_run = 1;
      m_lvl = 1;
      m_rem = m_div;
    end
    if (bus.load) begin
      m_pend = (bus.div_half == 0) ? 1 : int'(bus.div_half);
      m_pvld = 1;
    end
    m_rise = m_lvl & ~prev;
    m_fall = ~m_lvl & prev;
    if (m_rise) m_cnt = (m_cnt + 1) % 16;
  endtask

  function automatic logic [8:0] exp_vec();
    logic d;
`ifdef PHASE_DLY_EN
    int s;
    s = int'(bus.phase_sel);
    if (s > 3) s = 3;
    d = (s == 0) ? m_lvl : m_hist[s];
`else
    d = m_lvl;
`endif
    return {m_lvl, d, m_rise, m_fall, m_run, 4'(m_cnt)};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.clk_out, bus.clk_out_dly, bus.rise_stb, bus.fall_stb, bus.busy, bus.edge_cnt};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    rst    = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs_vec() !== 9'h000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs_vec(), 9'h000);
      end
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.rise_stb !== 1'b1 || bus.clk_out !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_rise got rise=%b clk=%b busy=%b want 1 1 1",
               bus.rise_stb, bus.clk_out, bus.busy);
    end
  endtask

  task automatic test_div1();
    int rises;
    bus.en = 1'b0;
    pulse_reset();
    bus.div_half = 8'd1;
    bus.load     = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    rises    = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      rises += int'(bus.rise_stb);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL div1 cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (rises != 20 || bus.edge_cnt !== 4'd4) begin
      failures++;
      $display("FAIL div1_count got rises=%0d cnt=%0d want rises=20 cnt=4", rises, bus.edge_cnt);
    end
  endtask

  task automatic test_reload();
    int guard;
    guard = 0;
    while (bus.clk_out !== 1'b0 && guard < 10) begin
      cyc();
      guard++;
    end
    checks++;
    if (bus.clk_out !== 1'b0) begin
      failures++;
      $display("FAIL reload_wait got clk_out=%b want 0", bus.clk_out);
    end
    bus.div_half = 8'd3;
    bus.load     = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      bus.load = 1'b0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reload cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    int highs, falls, rises;
    bus.en = 1'b0;
    pulse_reset();
    bus.div_half = 8'd4;
    bus.load     = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    cyc();
    checks++;
    if (bus.rise_stb !== 1'b1) begin
      failures++;
      $display("FAIL stop_start got rise=%b want 1", bus.rise_stb);
    end
    highs = 1;
    falls = 0;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) bus.en = 1'b0;
      highs += int'(bus.clk_out);
      falls += int'(bus.fall_stb);
      rises += int'(bus.rise_stb);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stop cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (highs != 4 || falls != 1 || rises != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_shape got highs=%0d falls=%0d rises=%0d busy=%b want 4 1 0 0",
               highs, falls, rises, bus.busy);
    end
  endtask

  task automatic test_zero_div();
    logic prev;
    bus.en = 1'b0;
    pulse_reset();
    bus.div_half = 8'd0;
    bus.load     = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    cyc();
    prev = bus.clk_out;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || bus.clk_out === prev) begin
        failures++;
        $display("FAIL zero_div cyc=%0d got=%h want=%h prev_clk=%b", i, obs_vec(), exp_vec(), prev);
      end
      prev = bus.clk_out;
    end
  endtask

  task automatic test_phase();
    bus.en = 1'b0;
    pulse_reset();
    bus.div_half = 8'd2;
    bus.load     = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int p = 0; p < 4; p++) begin
      bus.phase_sel = 2'(p);
      for (int i = 0; i < 12; i++) begin
        cyc();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL phase sel=%0d cyc=%0d got=%h want=%h", p, i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 9'h000) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs_vec(), 9'h000);
    end
    @(negedge clk);
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
      bus.load      = ($urandom_range(0, 11) == 0);
      bus.div_half  = 8'($urandom_range(0, 5));
      bus.phase_sel = 2'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 299) == 0);
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.load      = 1'b0;
    bus.div_half  = 8'd1;
    bus.phase_sel = 2'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_div1();
    test_reload();
    test_stop();
    test_zero_div();
    test_phase();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
